dct_block_serializer: RTL and testbench

- Reader side of the first DCT stage's 8x8 block output.
- Captures a complete 8x8 coefficient block in one cycle when the stage signals done.
- Streams the block out as eight 8-element vectors, one per accepted beat, with a valid/ready handshake.
- Sits between the first (column) DCT stage and the second (row) DCT stage, or the quantizer.

---
 rtl/dct_block_serializer.sv | 63 ++++++
 tb/tb_dct_block_serializer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dct_block_serializer.sv
// dct_block_serializer: captures an 8x8 coefficient block on load and streams it as eight valid/ready beats.
// Define DCT_SERIALIZER_TRANSPOSE_EN to emit beat k as element k of every column unit.
module dct_block_serializer #(
    parameter int SIZE = 10,
    parameter int DIM  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic signed [SIZE-1:0] data_in [DIM][DIM],
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SIZE-1:0] data_out [DIM],
    output logic [2:0]             out_idx,
    output logic                   out_last,
    output logic                   block_done,
    output logic                   overflow
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic                   block_done_q, overflow_q;
    logic signed [SIZE-1:0] buf_q [DIM][DIM];
    logic                   fire, accept;
    assign fire     = (state_q == STREAM) && out_ready;
    assign in_ready = (state_q == IDLE) || (fire && cnt_q == 3'd7);
    assign accept   = load && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            block_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            block_done_q <= fire && cnt_q == 3'd7;
            if (load && !in_ready) overflow_q <= 1'b1;
            if (accept) begin
                cnt_q   <= 3'd0;
                state_q <= STREAM;
            end else if (fire) begin
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_q <= IDLE;
            end
        end
    end
    // Buffer needs no reset: it is only visible while out_valid is high.
    always_ff @(posedge clk) begin
        if (accept) buf_q <= data_in;
    end
    assign out_valid  = state_q == STREAM;
    assign out_idx    = cnt_q;
    assign out_last   = out_valid && cnt_q == 3'd7;
    assign block_done = block_done_q;
    assign overflow   = overflow_q;
    for (genvar j = 0; j < DIM; j++) begin : g_out
`ifdef DCT_SERIALIZER_TRANSPOSE_EN
        assign data_out[j] = out_valid ? buf_q[j][cnt_q] : '0;
`else
        assign data_out[j] = out_valid ? buf_q[cnt_q][j] : '0;
`endif
    end
endmodule

// File: tb/tb_dct_block_serializer.sv
// tb_dct_block_serializer: directed and random stimulus checked against a beat-queue reference model.
module tb_dct_block_serializer;
    typedef int vec_t [8];
    logic clk, rst, load, out_ready;
    logic signed [9:0] din [8][8];
    logic signed [9:0] blk [8][8];
    logic signed [9:0] dout [8];
    logic in_ready, out_valid, out_last, block_done, overflow;
    logic [2:0] out_idx;
    vec_t exp_q [$];
    bit done_exp, ovf_exp;
    int total, fails;

    dct_block_serializer #(.SIZE(10), .DIM(8)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(din), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(dout), .out_idx(out_idx),
        .out_last(out_last), .block_done(block_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cyc(input bit r, input bit l, input bit rdy);
        int sz;
        bit ir;
        vec_t v;
        @(negedge clk);
        rst = r; load = l; out_ready = rdy; din = blk;
        #1;
        sz = exp_q.size();
        ir = sz == 0 || (sz == 1 && rdy);
        chk("out_valid", out_valid, sz > 0);
        chk("in_ready", in_ready, ir);
        chk("out_idx", out_idx, sz == 0 ? 0 : 8 - sz);
        chk("out_last", out_last, sz == 1);
        chk("block_done", block_done, done_exp);
        chk("overflow", overflow, ovf_exp);
        if (sz > 0) for (int e = 0; e < 8; e++) chk($sformatf("data_out[%0d]", e), dout[e], exp_q[0][e]);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            done_exp = 0;
            ovf_exp = 0;
        end else begin
            done_exp = sz == 1 && rdy;
            if (sz > 0 && rdy) void'(exp_q.pop_front());
            if (l && !ir) ovf_exp = 1;
            if (l && ir) for (int k = 0; k < 8; k++) begin
                for (int e = 0; e < 8; e++)
`ifdef DCT_SERIALIZER_TRANSPOSE_EN
                    v[e] = blk[e][k];
`else
                    v[e] = blk[k][e];
`endif
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic fill_seq(input bit neg);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++)
            blk[i][j] = neg ? 10'(-(8*i + j + 1)) : 10'(8*i + j);
    endtask

    task automatic fill_const(input int c);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = 10'(c);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = 10'($urandom_range(0, 1023));
    endtask

    task automatic drain(input int mode);
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) cyc(0, 0, mode == 0 ? 1'b1 : (c % 3 == 0));
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        clk = 0; rst = 1; load = 0; out_ready = 0;
        total = 0; fails = 0;
        fill_seq(0);
        din = blk;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        for (int c = 0; c < 10; c++) cyc(0, 0, 0);
        // single block, no stall
        cyc(0, 1, 1);
        drain(0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        // backpressure 1,0,0,...
        cyc(0, 1, 0);
        drain(1);
        cyc(0, 0, 0);
        // back-to-back with negated second block
        cyc(0, 1, 1);
        for (int c = 0; c < 20 && exp_q.size() > 1; c++) cyc(0, 0, 1);
        fill_seq(1);
        cyc(0, 1, 1);
        chk("b2b_queued", exp_q.size(), 8);
        drain(0);
        cyc(0, 0, 1);
        // overflow at beat 3
        fill_seq(0);
        cyc(0, 1, 1);
        for (int c = 0; c < 20 && exp_q.size() > 5; c++) cyc(0, 0, 1);
        fill_const(10'h155);
        cyc(0, 1, 1);
        fill_seq(0);
        drain(0);
        for (int c = 0; c < 3; c++) cyc(0, 0, 1);
        // reset at beat 4, then fresh load
        cyc(0, 1, 1);
        for (int c = 0; c < 20 && exp_q.size() > 4; c++) cyc(0, 0, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        fill_seq(1);
        cyc(0, 1, 1);
        drain(0);
        // random traffic
        for (int c = 0; c < 300; c++) begin
            fill_rand();
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
